// File: rtl/lc3b_types.sv
// Shared LC-3b memory-system types: arbiter FSM states, grant owner, cache-line word.
package lc3b_types;

  localparam int unsigned LC3B_LINE_W = 128;

  typedef logic [LC3B_LINE_W-1:0] lc3b_line;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SERVE_I = 2'd1,
    SERVE_D = 2'd2
  } arb_state_t;

  typedef enum logic {
    GRANT_I = 1'b0,
    GRANT_D = 1'b1
  } grant_t;

endpackage

// File: rtl/cache_arbiter.sv
// Arbitrates I-cache fills and D-cache fills/writebacks onto one physical memory port.
module cache_arbiter
  import lc3b_types::*;
#(
  parameter int unsigned ADDR_W = 16,
  parameter int unsigned LINE_W = LC3B_LINE_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_read,
  input  logic [ADDR_W-1:0] i_address,
  output logic [LINE_W-1:0] i_rdata,
  output logic              i_resp,
  input  logic              d_read,
  input  logic              d_write,
  input  logic [ADDR_W-1:0] d_address,
  input  logic [LINE_W-1:0] d_wdata,
  output logic [LINE_W-1:0] d_rdata,
  output logic              d_resp,
  output logic              pmem_read,
  output logic              pmem_write,
  output logic [ADDR_W-1:0] pmem_address,
  output logic [LINE_W-1:0] pmem_wdata,
  input  logic [LINE_W-1:0] pmem_rdata,
  input  logic              pmem_resp
);

  arb_state_t        state, state_next;
  grant_t            last_grant;
  logic [ADDR_W-1:0] addr_q;
  logic [LINE_W-1:0] wdata_q;
  logic              write_q;
  logic              d_req;
  logic              take;
  logic              pick_d;
  logic              serving;

  // D wins only if I is absent, or on a tie when I was served most recently.
  function automatic logic grant_to_d(input logic i_req, input logic dreq, input grant_t last);
    return dreq && (!i_req || last == GRANT_I);
  endfunction

  assign d_req  = d_read | d_write;
  assign take   = (state == IDLE) && (i_read || d_req);
  assign pick_d = grant_to_d(i_read, d_req, last_grant);

  always_comb begin
    state_next = state;
    case (state)
      IDLE:             if (i_read || d_req) state_next = pick_d ? SERVE_D : SERVE_I;
      SERVE_I, SERVE_D: if (pmem_resp) state_next = IDLE;
      default:          state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      last_grant <= GRANT_D;
      addr_q     <= '0;
      wdata_q    <= '0;
      write_q    <= 1'b0;
    end else begin
      state <= state_next;
      if (take) begin
        if (pick_d) begin
          last_grant <= GRANT_D;
          addr_q     <= d_address;
          write_q    <= d_write;
          wdata_q    <= d_write ? d_wdata : '0;
        end else begin
          last_grant <= GRANT_I;
          addr_q     <= i_address;
          write_q    <= 1'b0;
          wdata_q    <= '0;
        end
      end
    end
  end

  // Memory side is a pure function of state and latched request, so reset clears it at once.
  assign serving      = (state != IDLE);
  assign pmem_read    = serving && !write_q;
  assign pmem_write   = serving && write_q;
  assign pmem_address = serving ? addr_q : '0;
  assign pmem_wdata   = serving ? wdata_q : '0;

  assign i_resp  = (state == SERVE_I) && pmem_resp;
  assign d_resp  = (state == SERVE_D) && pmem_resp;
  assign i_rdata = pmem_rdata;
  assign d_rdata = pmem_rdata;

endmodule
